// File: rtl/uart_rx_loader.sv
// UART 8N1 receiver that writes each byte to consecutive memory addresses from 0.
// Define UART_PARITY_EN to receive 8E1 frames and drop bytes that fail even parity.
module uart_rx_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 16,
    parameter int NUM_BYTES    = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              receive,
    input  logic              rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              rx_LED,
    output logic              rx_done,
    output logic              frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W:0] CNT_LAST  = (ADDR_W + 1)'(NUM_BYTES);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_ARMED  = 4'd1;
    localparam logic [3:0] S_START  = 4'd2;
    localparam logic [3:0] S_DATA   = 4'd3;
    localparam logic [3:0] S_STOP   = 4'd5;
    localparam logic [3:0] S_RESYNC = 4'd6;
    localparam logic [3:0] S_WRITE  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;
`ifdef UART_PARITY_EN
    localparam logic [3:0] S_PARITY = 4'd4;
`endif

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_recv_q;
    logic            r_recv_qq;
    logic [3:0]      r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [ADDR_W:0] r_cnt;
    logic [7:0]      r_din;
    logic            r_we;
    logic            r_err;
    logic            r_par_bad;
    logic            w_rx;
    logic            w_arm;
    logic            w_bit_end;

    assign w_rx      = r_rx_sync;
    assign w_arm     = r_recv_q & ~r_recv_qq;
    assign w_bit_end = (r_clk_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_recv_q  <= 1'b0;
            r_recv_qq <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_recv_q  <= receive;
            r_recv_qq <= r_recv_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_cnt     <= '0;
            r_din     <= 8'h00;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_par_bad <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_arm) begin
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_par_bad <= 1'b0;
                        r_state   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!w_rx) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= w_rx ? S_ARMED : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_par_bad <= ^{w_rx, r_shift};
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (!w_rx) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESYNC;
                        end else if (r_par_bad) begin
                            // Parity failure with a good stop bit: drop the byte, stay in sync.
                            r_err     <= 1'b1;
                            r_par_bad <= 1'b0;
                            r_state   <= S_ARMED;
                        end else begin
                            r_we    <= 1'b1;
                            r_din   <= r_shift;
                            r_state <= S_WRITE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_RESYNC: begin
                    r_par_bad <= 1'b0;
                    if (w_rx) begin
                        r_state <= S_ARMED;
                    end
                end
                S_WRITE: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= ((r_cnt + 1'b1) == CNT_LAST) ? S_DONE : S_ARMED;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = r_cnt[ADDR_W-1:0];
    assign mem_din   = r_din;
    assign mem_we    = r_we;
    assign rx_LED    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign rx_done   = (r_state == S_DONE);
    assign frame_err = r_err;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Scoreboard bench for uart_rx_loader: serial stimulus, expected writes queued, monitor compares.
module tb_uart_rx_loader;

    localparam int CPB = 4;
    localparam int AW  = 16;
    localparam int NB  = 3;
`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          receive = 1'b0;
    logic          rx = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          rx_LED;
    logic          rx_done;
    logic          frame_err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          last;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  exp_cnt = 0;

    uart_rx_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .NUM_BYTES   (NB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .receive  (receive),
        .rx       (rx),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .rx_LED   (rx_LED),
        .rx_done  (rx_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected write.
    initial begin : monitor
        wr_t  e;
        logic prev_we = 1'b0;
        logic done_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (done_chk) begin
                check("done_after_last", rx_done, 1);
                check("led_after_last", rx_LED, 0);
                done_chk = 1'b0;
            end
            if (mem_we === 1'b1) begin
                check("we_gap", prev_we, 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr,
                             mem_din);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_din, e.data);
                    if (e.last) done_chk = 1'b1;
                    else check("led_in_load", rx_LED, 1);
                end
            end
            prev_we = mem_we;
        end
    end

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // A frame is written iff the stop bit is 1 and (when enabled) parity is even.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_good);
        wr_t e;
        if (stop && (par_good || !PAR)) begin
            e.addr = exp_cnt[AW-1:0];
            e.data = d;
            e.last = (exp_cnt + 1 == NB);
            exp_q.push_back(e);
            exp_cnt++;
        end
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_bit();
        end
`ifdef UART_PARITY_EN
        rx = (^d) ^ ~par_good;
        wait_bit();
`endif
        rx = stop;
        wait_bit();
        rx = 1'b1;
    endtask

    task automatic arm();
        @(posedge clk);
        #1 receive = 1'b1;
        repeat (3) @(posedge clk);
        #1 receive = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_cnt = 0;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_din"}, mem_din, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_led"}, rx_LED, 0);
        check({tag, "_done"}, rx_done, 0);
        check({tag, "_err"}, frame_err, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("idle_led", rx_LED, 0);

        // Basic load of three bytes.
        arm();
        @(negedge clk);
        check("armed_led", rx_LED, 1);
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("load1_done", rx_done, 1);
        check("load1_err", frame_err, 0);

        // Re-arm from DONE, glitch rejection, receive toggled mid-load.
        arm();
        @(negedge clk);
        check("rearm_done", rx_done, 0);
        check("rearm_led", rx_LED, 1);
        rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("glitch_led", rx_LED, 1);
        check("glitch_err", frame_err, 0);
        send_frame(8'h12, 1'b1, 1'b1);
        receive = 1'b1;
        send_frame(8'($urandom), 1'b1, 1'b1);
        receive = 1'b0;
        send_frame(8'($urandom), 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("load2_done", rx_done, 1);

        // Bad stop bit drops the byte without advancing the address.
        arm();
        send_frame(8'h55, 1'b0, 1'b1);
        wait_bit();
        send_frame(8'h66, 1'b1, 1'b1);
        @(negedge clk);
        check("badstop_err", frame_err, 1);
        send_frame(8'($urandom), 1'b1, 1'b1);
        send_frame(8'($urandom), 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("load3_done", rx_done, 1);
        check("load3_err_sticky", frame_err, 1);

        // Reset during DATA of the second byte.
        arm();
        send_frame(8'($urandom), 1'b1, 1'b1);
        rx = 1'b0;
        wait_bit();
        rx = 1'b1;
        wait_bit();
        rx = 1'b0;
        wait_bit();
        rst_n = 1'b0;
        rx = 1'b1;
        check_quiet("midreset");
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        arm();
        for (int i = 0; i < NB; i++) send_frame(8'($urandom), 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("load4_done", rx_done, 1);

`ifdef UART_PARITY_EN
        arm();
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        @(negedge clk);
        check("parity_err", frame_err, 1);
        send_frame(8'($urandom), 1'b1, 1'b1);
        send_frame(8'($urandom), 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("parity_done", rx_done, 1);
`endif

        // Randomised loads with error injection and random inter-frame gaps.
        for (int l = 0; l < 4; l++) begin
            arm();
            while (exp_cnt < NB) begin
                logic stop_ok;
                logic par_ok;
                int   gap;
                stop_ok = ($urandom_range(0, 3) != 0);
                par_ok  = ($urandom_range(0, 3) != 0);
                gap     = stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
                send_frame(8'($urandom), stop_ok, par_ok);
                for (int g = 0; g < gap; g++) wait_bit();
            end
            repeat (10) @(posedge clk);
            @(negedge clk);
            check("rand_done", rx_done, 1);
        end

        repeat (20) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
